gcd_job_arbiter: RTL and testbench
==================================

// Module: gcd_job_arbiter
// PURPOSE
//  Shares one Greatest_Common_Divisor engine among NUM_REQ requesters.
//  Round-robin selection of a pending request, issues it to the engine, returns the result tagged with requester ID.
//  Sits between client blocks and the single GCD engine instance; engine and arbiter share clk/rst_n.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  DATA_W       16    operand/result width; must match engine (16)
//  TIMEOUT_CYC  1023  BUSY-cycle limit before a job is aborted (GCD_ARB_TIMEOUT_EN only)
//  localparam ID_W = $clog2(NUM_REQ)
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               synchronous, active-low reset
//  req_valid    in   NUM_REQ         per-requester job pending; held with data until req_ready
//  req_a        in   NUM_REQ*DATA_W  operand a, requester i at [i*DATA_W +: DATA_W]
//  req_b        in   NUM_REQ*DATA_W  operand b, same packing
//  req_ready    out  NUM_REQ         one-hot, 1-cycle pulse: job of requester i accepted
//  eng_start    out  1               1-cycle start pulse to engine
//  eng_a        out  DATA_W          operand a to engine, stable from ISSUE until back in IDLE
//  eng_b        out  DATA_W          operand b to engine
//  eng_done     in   1               engine done, may stay high several cycles
//  eng_gcd      in   DATA_W          engine result, valid while eng_done=1
//  rsp_valid    out  1               1-cycle result pulse, no backpressure
//  rsp_id       out  ID_W            requester index of the result
//  rsp_gcd      out  DATA_W          result value
//  rsp_timeout  out  1               result aborted by timeout (0 without macro)
// BEHAVIOUR
//  All outputs registered. Reset: every output 0, state IDLE, rr_ptr = NUM_REQ-1.
//  FSM IDLE -> ISSUE -> BUSY -> DRAIN -> IDLE.
//  IDLE: if any req_valid, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//   Same edge: latch id, eng_a, eng_b; rr_ptr <= id; req_ready[id] high next cycle only; go ISSUE.
//  ISSUE: eng_start=1 for this single cycle; go BUSY.
//  BUSY: on first eng_done=1, rsp_gcd<=eng_gcd, rsp_id<=id, rsp_valid=1 next cycle only; go DRAIN.
//  DRAIN: stay until eng_done=0 (engine back in WAIT); then IDLE. No new grant while in DRAIN.
//  Only the first eng_done cycle counts: done held N cycles yields exactly one rsp_valid.
//  Latency: request seen in IDLE at edge k -> req_ready during cycle k+1, eng_start cycle k+1,
//   rsp_valid one cycle after the first done cycle.
//  Operands passed unmodified; zero operands allowed (engine returns a|b, gcd(0,0)=0).
//  req_valid of non-granted requesters ignored outside IDLE; dropping req_valid before req_ready is legal (no grant).
//  Requester re-asserting right after its response is served after every other pending requester.
//  eng_done while in IDLE/ISSUE is ignored.
//  Reset mid-job: job lost, no rsp_valid, outputs 0 on next cycle, next grant favours requester 0.
// CONFIGURATION
//  GCD_ARB_TIMEOUT_EN defined: counter clears on entering BUSY, increments each BUSY cycle.
//   When count reaches TIMEOUT_CYC with no eng_done: rsp_valid=1, rsp_timeout=1, rsp_gcd=0, go DRAIN.
//   Normal result in the same cycle as the limit: normal result wins, rsp_timeout=0.
//  Not defined: no counter, BUSY waits indefinitely, rsp_timeout tied 0.
// TESTING
//  1. req_valid=0001, a=48, b=18 -> one req_ready[0] pulse, one eng_start, rsp_valid with rsp_id=0, rsp_gcd=6.
//  2. req_valid=1111 together, pairs (12,8),(35,14),(9,27),(17,5) -> rsp order id 0,1,2,3; gcd 4,7,9,1.
//  3. req 0 and req 2 held continuously -> grants alternate 0,2,0,2; req 1/3 never granted.
//  4. (0,35)->35; (0,0)->0; (65535,65535)->65535; engine done held 2 cycles -> exactly 1 rsp_valid each.
//  5. rst_n=0 for 1 cycle during BUSY -> outputs all 0 next cycle, no rsp_valid, next grant goes to requester 0.
//  6. GCD_ARB_TIMEOUT_EN, TIMEOUT_CYC=15, engine stub never asserts done -> rsp_valid, rsp_timeout=1, rsp_gcd=0 after 15 BUSY cycles.

Source files
------------

// File: rtl/gcd_job_arbiter_if.sv
// Handshake bundle between requesters, the GCD job arbiter and the shared GCD engine.
// The slave modport is the arbiter side; the master modport is the requester/engine side.
interface gcd_job_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_a;
  logic [DATA_W-1:0]         eng_b;
  logic                      eng_done;
  logic [DATA_W-1:0]         eng_gcd;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_gcd;
  logic                      rsp_timeout;

  modport slave (
    input  req_valid, req_a, req_b, eng_done, eng_gcd,
    output req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_gcd, rsp_timeout
  );

  modport master (
    output req_valid, req_a, req_b, eng_done, eng_gcd,
    input  req_ready, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_gcd, rsp_timeout
  );
endinterface

// File: rtl/gcd_job_arbiter.sv
// Round-robin arbiter sharing one GCD engine among NUM_REQ requesters.
// Define GCD_ARB_TIMEOUT_EN to abort BUSY jobs after TIMEOUT_CYC cycles without eng_done.
module gcd_job_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 16
`ifdef GCD_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1023
`endif
) (
  input logic              clk,
  input logic              rst_n,
  gcd_job_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                eng_start_q, eng_start_d;
  logic [DATA_W-1:0]   eng_a_q, eng_a_d;
  logic [DATA_W-1:0]   eng_b_q, eng_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_gcd_q, rsp_gcd_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                grant_vld_c;
  logic [ID_W-1:0]     grant_id_c;
  logic [ID_W-1:0]     scan_c;
  logic [DATA_W-1:0]   sel_a_c, sel_b_c;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // First pending requester after the last granted one, wrapping around.
  always_comb begin : rr_pick
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    scan_c      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      scan_c = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!grant_vld_c && bus.req_valid[scan_c]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = scan_c;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin : operand_sel
    sel_a_c = '0;
    sel_b_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_c) begin
        sel_a_c = bus.req_a[i*DATA_W +: DATA_W];
        sel_b_c = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : fsm_next
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    req_ready_d   = '0;
    eng_start_d   = 1'b0;
    eng_a_d       = eng_a_q;
    eng_b_d       = eng_b_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_gcd_d     = rsp_gcd_q;
    rsp_timeout_d = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          id_d        = grant_id_c;
          rr_ptr_d    = grant_id_c;
          req_ready_d = NUM_REQ'(1) << grant_id_c;
          eng_start_d = 1'b1;
          eng_a_d     = sel_a_c;
          eng_b_d     = sel_b_c;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        // A real result beats a timeout landing on the same cycle.
        if (bus.eng_done) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_gcd_d   = bus.eng_gcd;
          state_d     = DRAIN;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_id_d      = id_q;
          rsp_gcd_d     = '0;
          state_d       = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (!bus.eng_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      req_ready_q   <= '0;
      eng_start_q   <= 1'b0;
      eng_a_q       <= '0;
      eng_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_gcd_q     <= '0;
      rsp_timeout_q <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      req_ready_q   <= req_ready_d;
      eng_start_q   <= eng_start_d;
      eng_a_q       <= eng_a_d;
      eng_b_q       <= eng_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_gcd_q     <= rsp_gcd_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_a       = eng_a_q;
  assign bus.eng_b       = eng_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_gcd     = rsp_gcd_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Bench for gcd_job_arbiter: requester/engine stubs plus a round-robin scoreboard model.
// Build with GCD_ARB_TIMEOUT_EN to also exercise the BUSY timeout abort.
`timescale 1ns/1ps
module tb_gcd_job_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcd_job_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  gcd_job_arbiter #(
    .NUM_REQ(NR),
    .DATA_W(DW)
`ifdef GCD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(15)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int id;
    int gcd;
    bit to;
  } rsp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_grant;
  int grant_log[$];
  rsp_t exp_q[$];

  logic [DW-1:0] job_a[NR];
  logic [DW-1:0] job_b[NR];
  logic [DW-1:0] job_exp[NR];
  bit            job_to[NR];
  bit            pending[NR];
  bit            keep[NR];

  int            eng_lat = 3;
  int            eng_hold = 1;
  bit            eng_never = 1'b0;
  int            lat_cnt = 0;
  int            hold_cnt = 0;
  logic [DW-1:0] st_a, st_b;

  function automatic logic [DW-1:0] euclid(input logic [DW-1:0] a_in, input logic [DW-1:0] b_in);
    logic [DW-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first pending requester after the last grant.
  function automatic int rr_expect();
    for (int off = 1; off <= int'(NR); off++) begin
      int idx;
      idx = (last_grant + off) % int'(NR);
      if (pending[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_job(input int i, input int a, input int b, input int e, input bit k);
    job_a[i]   = DW'(a);
    job_b[i]   = DW'(b);
    job_exp[i] = DW'(e);
    job_to[i]  = 1'b0;
    keep[i]    = k;
    pending[i] = 1'b1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_valid[IW'(i)]   = pending[i];
      bus.req_a[i*DW +: DW]   = job_a[i];
      bus.req_b[i*DW +: DW]   = job_b[i];
    end
  endtask

  task automatic compare_cycle();
    int n;
    int g;
    rsp_t e;
    n = 0;
    g = -1;
    for (int i = 0; i < int'(NR); i++) begin
      if (bus.req_ready[IW'(i)]) begin
        n++;
        g = i;
      end
    end
    chk("ready_onehot", n > 1, 0);
    chk("start_with_ready", bus.eng_start, n == 1);
    if (n == 1) begin
      chk("grant_id", g, rr_expect());
      chk("grant_outside_drain", bus.eng_done, 0);
      chk("grant_with_job_open", exp_q.size(), 0);
      chk("eng_a", bus.eng_a, job_a[g]);
      chk("eng_b", bus.eng_b, job_b[g]);
      exp_q.push_back('{g, int'(job_exp[g]), job_to[g]});
      grant_log.push_back(g);
      last_grant = g;
      start_cyc  = cyc;
      if (!keep[g]) pending[g] = 1'b0;
    end
    if (bus.rsp_valid) begin
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_gcd", bus.rsp_gcd, e.gcd);
        chk("rsp_timeout", bus.rsp_timeout, e.to);
        if (e.to) chk("timeout_latency", cyc - start_cyc, 16);
      end
    end else begin
      chk("rsp_timeout_idle", bus.rsp_timeout, 0);
    end
  endtask

  // Engine stub: done rises eng_lat cycles after start and holds for eng_hold cycles.
  task automatic stub_update();
    if (!rst_n) begin
      lat_cnt      = 0;
      hold_cnt     = 0;
      bus.eng_done = 1'b0;
      bus.eng_gcd  = '0;
      return;
    end
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) begin
        bus.eng_done = 1'b0;
        bus.eng_gcd  = '0;
      end
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        bus.eng_done = 1'b1;
        bus.eng_gcd  = euclid(st_a, st_b);
        hold_cnt     = eng_hold;
      end
    end
    if (bus.eng_start) begin
      st_a    = bus.eng_a;
      st_b    = bus.eng_b;
      lat_cnt = eng_never ? 0 : eng_lat;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    compare_cycle();
    stub_update();
    drive_reqs();
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < int'(NR); i++) if (pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_done(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || any_pending() || lat_cnt != 0 || hold_cnt != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("done_within_bound", exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic run_grants(input int count, input int max_cyc);
    int n;
    n = 0;
    while (grant_log.size() < count && n < max_cyc) begin
      step();
      n++;
    end
    chk("grants_within_bound", grant_log.size(), count);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_eng_start"}, bus.eng_start, 0);
    chk({tag, "_eng_a"}, bus.eng_a, 0);
    chk({tag, "_eng_b"}, bus.eng_b, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_gcd"}, bus.rsp_gcd, 0);
    chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    last_grant = int'(NR) - 1;
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr[4];
    rst_n        = 1'b0;
    bus.eng_done = 1'b0;
    bus.eng_gcd  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      pending[i] = 1'b0;
      keep[i]    = 1'b0;
      job_a[i]   = '0;
      job_b[i]   = '0;
      job_exp[i] = '0;
      job_to[i]  = 1'b0;
    end
    drive_reqs();

    apply_reset(3);
    check_outputs_zero("reset");

    // 1: single job 48,18 -> 6 from requester 0
    grant_log.delete();
    set_job(0, 48, 18, 6, 1'b0);
    run_until_done(100);
    chk("t1_grant_count", grant_log.size(), 1);
    chk("t1_grant_id", grant_log[0], 0);

    // 2: all four together from reset pointer -> 0,1,2,3
    apply_reset(2);
    grant_log.delete();
    set_job(0, 12, 8, 4, 1'b0);
    set_job(1, 35, 14, 7, 1'b0);
    set_job(2, 9, 27, 9, 1'b0);
    set_job(3, 17, 5, 1, 1'b0);
    run_until_done(200);
    exp_rr = '{0, 1, 2, 3};
    chk("t2_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_order", grant_log[i], exp_rr[i]);

    // 3: requesters 0 and 2 held continuously alternate
    grant_log.delete();
    eng_lat = 2;
    set_job(0, 10, 4, 2, 1'b1);
    set_job(2, 21, 14, 7, 1'b1);
    run_grants(4, 200);
    keep[0] = 1'b0; pending[0] = 1'b0;
    keep[2] = 1'b0; pending[2] = 1'b0;
    drive_reqs();
    run_until_done(100);
    exp_rr = '{0, 2, 0, 2};
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t3_alternate", grant_log[i], exp_rr[i]);

    // 4: spurious done in IDLE, zero/max operands, done held several cycles
    bus.eng_done = 1'b1;
    bus.eng_gcd  = 16'd99;
    hold_cnt     = 2;
    repeat (4) step();
    eng_hold = 2;
    set_job(1, 0, 35, 35, 1'b0);
    run_until_done(100);
    set_job(2, 0, 0, 0, 1'b0);
    run_until_done(100);
    eng_hold = 3;
    eng_lat  = 6;
    grant_log.delete();
    set_job(3, 65535, 65535, 65535, 1'b0);
    repeat (4) step();
    set_job(1, 5, 10, 5, 1'b0);
    repeat (2) step();
    pending[1] = 1'b0;
    drive_reqs();
    run_until_done(100);
    chk("t4_dropped_req_not_granted", grant_log.size(), 1);

    // 5: reset while BUSY loses the job and restarts the pointer
    eng_lat  = 40;
    eng_hold = 1;
    grant_log.delete();
    set_job(0, 100, 75, 25, 1'b0);
    run_grants(1, 50);
    repeat (3) step();
    rst_n = 1'b0;
    exp_q.delete();
    last_grant = int'(NR) - 1;
    step();
    check_outputs_zero("midjob_reset");
    rst_n = 1'b1;
    eng_lat = 3;
    grant_log.delete();
    set_job(0, 7, 21, 7, 1'b0);
    set_job(1, 30, 12, 6, 1'b0);
    run_until_done(100);
    chk("t5_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    chk("t5_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 1);

`ifdef GCD_ARB_TIMEOUT_EN
    // 6: engine never completes -> timeout response after 15 BUSY cycles
    eng_never = 1'b1;
    grant_log.delete();
    set_job(2, 40, 24, 0, 1'b0);
    job_to[2] = 1'b1;
    run_until_done(100);
    chk("t6_grant", grant_log.size(), 1);
    eng_never = 1'b0;
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
